ifetch: RTL and testbench

//  Instruction fetch stage: owns the PC, drives the word address into instruction memory
//  (async-read, word index = addr[9:2]) and consumes the returned instruction word.

---
 rtl/ifetch.sv | 83 ++++++++
 tb/tb_ifetch.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch stage: PC register, async instruction memory port, one-entry output slot.
// Optional IFETCH_ALIGN_CHECK_EN: keep redirect targets unmodified and fault on misaligned PCs.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NMEM     = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_cnt
);
  typedef enum logic [1:0] {BOOT, RUN, FLT} state_t;

  localparam logic [31:0] LIMIT = 32'(NMEM * 4);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] target;
  logic        load;
  logic        legal;

  assign im_addr = pc;
  assign load    = ~out_valid | out_ready;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign target = redirect_pc;
  assign legal  = (pc < LIMIT) && (pc[1:0] == 2'b00);
`else
  assign target = {redirect_pc[31:2], 2'b00};
  assign legal  = (pc < LIMIT);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
      fault     <= 1'b0;
      fault_pc  <= '0;
      fetch_cnt <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN, FLT: begin
          if (redirect) begin
            // Redirect discards whatever sits in the slot, even if decode takes it now.
            pc        <= target;
            out_valid <= 1'b0;
            fault     <= 1'b0;
            state     <= RUN;
          end else if (state == RUN) begin
            if (out_valid && out_ready) fetch_cnt <= fetch_cnt + 32'd1;
            if (load) begin
              if (legal) begin
                out_inst  <= im_data;
                out_pc    <= pc;
                out_valid <= 1'b1;
                pc        <= pc + 32'd4;
              end else begin
                fault     <= 1'b1;
                fault_pc  <= pc;
                out_valid <= 1'b0;
                state     <= FLT;
              end
            end
          end
        end
        default: state <= BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch; memory model is an async-read array in the bench.
module tb_ifetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] im_addr, im_data;
  logic        out_valid, out_ready;
  logic [31:0] out_inst, out_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc, fetch_cnt;

  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign im_data = mem[im_addr[9:2]];

  ifetch #(.RESET_PC(32'h0), .NMEM(256)) dut (
    .clk(clk), .rst(rst), .im_addr(im_addr), .im_data(im_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .fault(fault), .fault_pc(fault_pc),
    .fetch_cnt(fetch_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44; mem[4] = 32'h55;
    rst = 1'b1; out_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;

    // Reset state
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    chk("rst_addr", im_addr, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    rst = 1'b0;

    // Boot cycle: no capture
    step();
    chk("boot_valid", 32'(out_valid), 32'd0);
    chk("boot_addr", im_addr, 32'd0);

    // Streaming fetch
    step();
    chk("s0_valid", 32'(out_valid), 32'd1);
    chk("s0_pc", out_pc, 32'h0);
    chk("s0_inst", out_inst, 32'h11);
    step();
    chk("s1_pc", out_pc, 32'h4);
    chk("s1_inst", out_inst, 32'h22);
    chk("s1_cnt", fetch_cnt, 32'd1);
    step();
    chk("s2_pc", out_pc, 32'h8);
    chk("s2_inst", out_inst, 32'h33);
    chk("s2_cnt", fetch_cnt, 32'd2);
    step();
    chk("s3_pc", out_pc, 32'hC);
    chk("s3_cnt", fetch_cnt, 32'd3);

    // Backpressure: everything held
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_pc", out_pc, 32'hC);
      chk("bp_inst", out_inst, 32'h44);
      chk("bp_addr", im_addr, 32'h10);
      chk("bp_cnt", fetch_cnt, 32'd3);
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    chk("rel_pc", out_pc, 32'h10);
    chk("rel_inst", out_inst, 32'h55);
    chk("rel_cnt", fetch_cnt, 32'd4);

    // Redirect discards the presented instruction
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("rd_valid", 32'(out_valid), 32'd0);
    chk("rd_addr", im_addr, 32'h40);
    chk("rd_cnt", fetch_cnt, 32'd4);
    step();
    chk("rd_pc", out_pc, 32'h40);
    chk("rd_inst", out_inst, 32'hA000_0010);
    chk("rd_valid2", 32'(out_valid), 32'd1);

    // Last legal word, then out-of-range fault
    redirect = 1'b1; redirect_pc = 32'h3FC;
    step();
    redirect = 1'b0;
    chk("top_cnt", fetch_cnt, 32'd4);
    step();
    chk("top_pc", out_pc, 32'h3FC);
    chk("top_inst", out_inst, 32'hA000_00FF);
    step();
    chk("flt", 32'(fault), 32'd1);
    chk("flt_pc", fault_pc, 32'h400);
    chk("flt_valid", 32'(out_valid), 32'd0);
    chk("flt_cnt", fetch_cnt, 32'd5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flt_hold", 32'(fault), 32'd1);
      chk("flt_addr", im_addr, 32'h400);
      chk("flt_hvalid", 32'(out_valid), 32'd0);
    end
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_addr", im_addr, 32'h0);
    step();
    chk("clr_pc", out_pc, 32'h0);
    chk("clr_inst", out_inst, 32'h11);
    chk("clr_cnt", fetch_cnt, 32'd5);

    // Misaligned redirect target
    redirect = 1'b1; redirect_pc = 32'h42;
    step();
    redirect = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("mis_addr", im_addr, 32'h42);
    step();
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_fpc", fault_pc, 32'h42);
    chk("mis_valid", 32'(out_valid), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    step();
    step();
    step();
`else
    chk("mis_addr", im_addr, 32'h40);
    step();
    chk("mis_pc", out_pc, 32'h40);
    chk("mis_fault", 32'(fault), 32'd0);
    step();
    step();
`endif
    chk("pre_rst_cnt", fetch_cnt, 32'd7);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);

    // Mid-run reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_cnt", fetch_cnt, 32'd0);
    chk("mr_addr", im_addr, 32'h0);
    // Redirect during BOOT is ignored
    redirect = 1'b1; redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    chk("mb_valid", 32'(out_valid), 32'd0);
    chk("mb_addr", im_addr, 32'h0);
    step();
    chk("mb_pc", out_pc, 32'h0);
    chk("mb_inst", out_inst, 32'h11);
    chk("mb_valid2", 32'(out_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
